mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/core_types_pkg.sv | 31 +++
 rtl/load_align.sv | 41 ++++
 rtl/mem_wb_stage.sv | 149 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: load size codes, MEM/WB writeback bundle
// and MEM/WB stage FSM states.
package core_types_pkg;

  localparam int XLEN_MAX  = 64;
  localparam int RADDR_MAX = 8;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_funct3_e;

  typedef enum logic {
    RUN      = 1'b0,
    WAIT_MEM = 1'b1
  } mem_wb_state_e;

  // Sized for the widest core; stages use the low bits.
  typedef struct packed {
    logic                 valid;
    logic [RADDR_MAX-1:0] rd;
    logic [XLEN_MAX-1:0]  data;
    logic                 Wreg;
  } mem_wb_out_t;

endpackage

// File: rtl/load_align.sv
// Load data extraction: picks the addressed byte/half/word lane
// out of the memory read word and sign/zero extends it.
module load_align
  import core_types_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            rdata,
  input  logic [$clog2(XLEN/8)-1:0]  lane,
  input  logic [2:0]                 funct3,
  output logic [XLEN-1:0]            data
);

  localparam int LANE_W = $clog2(XLEN/8);

  logic [LANE_W-1:0] h_lane;
  logic [LANE_W-1:0] w_lane;
  logic [7:0]        b;
  logic [15:0]       h;
  logic [31:0]       w;

  always_comb begin
    h_lane = lane & ~LANE_W'(1);
    w_lane = lane & ~LANE_W'(3);
    b      = rdata[{lane, 3'b000} +: 8];
    h      = rdata[{h_lane, 3'b000} +: 16];
    w      = rdata[{w_lane, 3'b000} +: 32];
    data   = rdata;
    unique case (funct3)
      F3_LB:   data = XLEN'($signed(b));
      F3_LBU:  data = XLEN'(b);
      F3_LH:   data = XLEN'($signed(h));
      F3_LHU:  data = XLEN'(h);
      F3_LW:   data = XLEN'($signed(w));
      F3_LWU:  data = (XLEN == 64) ? XLEN'(w) : rdata;
      F3_LD:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: registers ALU results and aligned load
// data, stalling upstream while a load waits for memory.
module mem_wb_stage
  import core_types_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               in_valid,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]    in_result,
  input  logic               in_Wreg,
  input  logic               in_isLoad,
  input  logic [2:0]         in_funct3,
  input  logic               flush,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               dmem_rvalid,
  output logic               stall_req,
  output logic               out_valid,
  output logic [RADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]    out_data,
  output logic               out_Wreg,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data
);

  localparam int LANE_W = $clog2(XLEN/8);

  mem_wb_state_e      state_q, state_d;
  mem_wb_out_t        out_q, out_d;
  logic [RADDR_W-1:0] pend_rd_q, pend_rd_d;
  logic               pend_wreg_q, pend_wreg_d;
  logic [2:0]         pend_f3_q, pend_f3_d;
  logic [LANE_W-1:0]  pend_lane_q, pend_lane_d;

  logic [LANE_W-1:0]  al_lane;
  logic [2:0]         al_f3;
  logic [XLEN-1:0]    al_data;
  logic               take;
  logic               stall;
  logic               unused_ok;

  function automatic mem_wb_out_t pack_wb(
    input logic [RADDR_W-1:0] rd,
    input logic [XLEN-1:0]    d,
    input logic               we
  );
    mem_wb_out_t o;
    o       = '0;
    o.valid = 1'b1;
    o.rd    = RADDR_MAX'(rd);
    o.data  = XLEN_MAX'(d);
    o.Wreg  = we && (rd != '0);
    return o;
  endfunction

  assign take = (state_q == RUN) && in_valid && !flush;

  // One aligner serves both the hit path and the pending load.
  always_comb begin
    al_lane = in_result[LANE_W-1:0];
    al_f3   = in_funct3;
    if (state_q == WAIT_MEM) begin
      al_lane = pend_lane_q;
      al_f3   = pend_f3_q;
    end
  end

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata (dmem_rdata),
    .lane  (al_lane),
    .funct3(al_f3),
    .data  (al_data)
  );

  always_comb begin
    state_d     = state_q;
    out_d       = '0;
    pend_rd_d   = pend_rd_q;
    pend_wreg_d = pend_wreg_q;
    pend_f3_d   = pend_f3_q;
    pend_lane_d = pend_lane_q;
    stall       = 1'b0;
    unique case (state_q)
      RUN: begin
        if (take) begin
          if (!in_isLoad) begin
            out_d = pack_wb(in_rd, in_result, in_Wreg);
          end else if (dmem_rvalid) begin
            out_d = pack_wb(in_rd, al_data, in_Wreg);
          end else begin
            state_d     = WAIT_MEM;
            pend_rd_d   = in_rd;
            pend_wreg_d = in_Wreg;
            pend_f3_d   = in_funct3;
            pend_lane_d = in_result[LANE_W-1:0];
            stall       = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (dmem_rvalid) begin
          out_d   = pack_wb(pend_rd_q, al_data, pend_wreg_q);
          state_d = RUN;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= RUN;
      out_q       <= '0;
      pend_rd_q   <= '0;
      pend_wreg_q <= 1'b0;
      pend_f3_q   <= '0;
      pend_lane_q <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      pend_rd_q   <= pend_rd_d;
      pend_wreg_q <= pend_wreg_d;
      pend_f3_q   <= pend_f3_d;
      pend_lane_q <= pend_lane_d;
    end
  end

  assign stall_req = stall && nReset;

  assign out_valid = out_q.valid;
  assign out_rd    = out_q.rd[RADDR_W-1:0];
  assign out_data  = out_q.data[XLEN-1:0];
  assign out_Wreg  = out_q.Wreg;

  assign fwd_valid = out_valid;
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_data;

  assign unused_ok = ^{out_q.rd, out_q.data};

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: XLEN=32 and XLEN=64 instances share
// stimulus; outputs are compared against a transaction-level model.
module tb_mem_wb_stage;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        in_valid, in_Wreg, in_isLoad, flush, dmem_rvalid;
  logic [4:0]  in_rd;
  logic [63:0] in_result, dmem_rdata;
  logic [2:0]  in_funct3;

  logic        s32, v32, w32, fv32;
  logic [4:0]  rd32, frd32;
  logic [31:0] d32, fd32;
  logic        s64, v64, w64, fv64;
  logic [4:0]  rd64, frd64;
  logic [63:0] d64, fd64;

  int checks = 0;
  int failures = 0;

  bit          pend;
  logic [4:0]  prd;
  logic        pwe;
  logic [2:0]  pf3;
  logic [63:0] paddr;
  int          nst;

  always #5 Clock = ~Clock;

  mem_wb_stage #(.XLEN(32), .RADDR_W(5)) dut32 (
    .Clock(Clock), .nReset(nReset),
    .in_valid(in_valid), .in_rd(in_rd),
    .in_result(in_result[31:0]), .in_Wreg(in_Wreg),
    .in_isLoad(in_isLoad), .in_funct3(in_funct3),
    .flush(flush), .dmem_rdata(dmem_rdata[31:0]),
    .dmem_rvalid(dmem_rvalid), .stall_req(s32),
    .out_valid(v32), .out_rd(rd32), .out_data(d32),
    .out_Wreg(w32), .fwd_valid(fv32), .fwd_rd(frd32),
    .fwd_data(fd32)
  );

  mem_wb_stage #(.XLEN(64), .RADDR_W(5)) dut64 (
    .Clock(Clock), .nReset(nReset),
    .in_valid(in_valid), .in_rd(in_rd),
    .in_result(in_result), .in_Wreg(in_Wreg),
    .in_isLoad(in_isLoad), .in_funct3(in_funct3),
    .flush(flush), .dmem_rdata(dmem_rdata),
    .dmem_rvalid(dmem_rvalid), .stall_req(s64),
    .out_valid(v64), .out_rd(rd64), .out_data(d64),
    .out_Wreg(w64), .fwd_valid(fv64), .fwd_rd(frd64),
    .fwd_data(fd64)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load result from the size/sign rules, using plain arithmetic.
  function automatic logic [63:0] ref_load(input int xlen,
      input logic [63:0] rdata, input logic [63:0] addr,
      input logic [2:0] f3);
    longint unsigned w, v;
    int lane;
    w = (xlen == 32) ? (rdata & 64'hFFFF_FFFF) : rdata;
    lane = (xlen == 32) ? int'(addr % 4) : int'(addr % 8);
    case (f3)
      3'd0: begin
        v = (w >> (8 * lane)) % 256;
        if (v >= 128) v = v - 256;
      end
      3'd4: v = (w >> (8 * lane)) % 256;
      3'd1: begin
        v = (w >> (8 * (lane / 2 * 2))) % 65536;
        if (v >= 32768) v = v - 65536;
      end
      3'd5: v = (w >> (8 * (lane / 2 * 2))) % 65536;
      3'd2: begin
        v = (w >> (8 * (lane / 4 * 4))) % 64'd4294967296;
        if (v >= 64'd2147483648) v = v - 64'd4294967296;
      end
      3'd6: begin
        if (xlen == 64) v = (w >> (8 * (lane / 4 * 4))) % 64'd4294967296;
        else v = w;
      end
      default: v = w;
    endcase
    if (xlen == 32) v = v % 64'd4294967296;
    return v;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_st32"}, {63'd0, s32}, 64'd0);
    chk({tag, "_st64"}, {63'd0, s64}, 64'd0);
    chk({tag, "_v32"}, {63'd0, v32}, 64'd0);
    chk({tag, "_v64"}, {63'd0, v64}, 64'd0);
    chk({tag, "_rd32"}, {59'd0, rd32}, 64'd0);
    chk({tag, "_d32"}, {32'd0, d32}, 64'd0);
    chk({tag, "_d64"}, d64, 64'd0);
    chk({tag, "_we64"}, {63'd0, w64}, 64'd0);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_rd = 0; in_result = 0; in_Wreg = 0;
    in_isLoad = 0; in_funct3 = 0; flush = 0;
    dmem_rdata = 0; dmem_rvalid = 0;
  endtask

  // One clock: check stall before the edge, outputs after it.
  task automatic cycle();
    logic        ev, ewe, est, ld;
    logic [4:0]  erd;
    logic [2:0]  f3;
    logic [63:0] addr, e32, e64;
    #1;
    ev = 0; ewe = 0; est = 0; erd = 0; ld = 0;
    f3 = 0; addr = 0;
    if (pend) begin
      if (dmem_rvalid) begin
        ev = 1; erd = prd; ewe = pwe; f3 = pf3; addr = paddr;
        ld = 1; pend = 0;
      end else begin
        est = 1;
      end
    end else if (in_valid && !flush) begin
      if (!in_isLoad) begin
        ev = 1; erd = in_rd; ewe = in_Wreg;
      end else if (dmem_rvalid) begin
        ev = 1; erd = in_rd; ewe = in_Wreg;
        f3 = in_funct3; addr = in_result; ld = 1;
      end else begin
        pend = 1; prd = in_rd; pwe = in_Wreg;
        pf3 = in_funct3; paddr = in_result; est = 1;
      end
    end
    if (erd == 0) ewe = 0;
    if (!ev) begin
      e32 = 0; e64 = 0;
    end else if (ld) begin
      e32 = ref_load(32, dmem_rdata, addr, f3);
      e64 = ref_load(64, dmem_rdata, addr, f3);
    end else begin
      e32 = in_result & 64'hFFFF_FFFF;
      e64 = in_result;
    end
    chk("stall32", {63'd0, s32}, {63'd0, est});
    chk("stall64", {63'd0, s64}, {63'd0, est});
    if (s32) nst++;
    @(posedge Clock);
    #1;
    chk("valid32", {63'd0, v32}, {63'd0, ev});
    chk("rd32", {59'd0, rd32}, {59'd0, erd});
    chk("data32", {32'd0, d32}, e32);
    chk("wreg32", {63'd0, w32}, {63'd0, ewe});
    chk("fwdv32", {63'd0, fv32}, {63'd0, ev});
    chk("fwdrd32", {59'd0, frd32}, {59'd0, erd});
    chk("fwdd32", {32'd0, fd32}, e32);
    chk("valid64", {63'd0, v64}, {63'd0, ev});
    chk("rd64", {59'd0, rd64}, {59'd0, erd});
    chk("data64", d64, e64);
    chk("wreg64", {63'd0, w64}, {63'd0, ewe});
    chk("fwdv64", {63'd0, fv64}, {63'd0, ev});
    chk("fwdrd64", {59'd0, frd64}, {59'd0, erd});
    chk("fwdd64", fd64, e64);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [63:0] r,
                     input logic we, input logic fl);
    idle_inputs();
    in_valid = 1; in_rd = rd; in_result = r; in_Wreg = we; flush = fl;
  endtask

  task automatic load(input logic [4:0] rd, input logic [63:0] a,
                      input logic [2:0] f3, input logic [63:0] rdat,
                      input logic rv);
    idle_inputs();
    in_valid = 1; in_rd = rd; in_result = a; in_Wreg = 1;
    in_isLoad = 1; in_funct3 = f3; dmem_rdata = rdat; dmem_rvalid = rv;
  endtask

  initial begin
    pend = 0; nst = 0;
    idle_inputs();
    nReset = 0;
    // A stalling load is presented while in reset.
    in_valid = 1; in_isLoad = 1; in_rd = 3;
    #3;
    chk_idle("rst_a");
    @(posedge Clock); #1;
    chk_idle("rst_b");
    idle_inputs();
    nReset = 1;

    alu(5'd5, 64'h1234_5678, 1, 0);
    cycle();
    chk("alu_lit_d32", {32'd0, d32}, 64'h1234_5678);
    chk("alu_lit_rd", {59'd0, rd32}, 64'd5);
    chk("alu_lit_we", {63'd0, w32}, 64'd1);

    load(5'd7, 64'h1003, 3'b000, 64'h80FF_0011, 1);
    cycle();
    chk("lb_lit", {32'd0, d32}, 64'hFFFF_FF80);
    load(5'd7, 64'h1003, 3'b100, 64'h80FF_0011, 1);
    cycle();
    chk("lbu_lit", {32'd0, d32}, 64'h0000_0080);
    load(5'd8, 64'h1002, 3'b101, 64'h80FF_0011, 1);
    cycle();
    chk("lhu_lit", {32'd0, d32}, 64'h0000_80FF);

    nst = 0;
    load(5'd9, 64'h2000, 3'b010, 64'h0, 0);
    cycle(); cycle(); cycle();
    chk("stall_cnt", 64'(nst), 64'd3);
    dmem_rvalid = 1; dmem_rdata = 64'hCAFE_BABE;
    cycle();
    chk("wait_lit_v", {63'd0, v32}, 64'd1);
    chk("wait_lit_d", {32'd0, d32}, 64'hCAFE_BABE);

    alu(5'd4, 64'h55, 1, 1);
    cycle();
    chk("flush_lit_v", {63'd0, v32}, 64'd0);
    chk("flush_lit_we", {63'd0, w32}, 64'd0);
    alu(5'd0, 64'h77, 1, 0);
    cycle();
    chk("rd0_lit_we", {63'd0, w32}, 64'd0);

    // Asynchronous clear of a valid output, mid-cycle.
    alu(5'd6, 64'hABCD, 1, 0);
    cycle();
    idle_inputs();
    nReset = 0;
    #2;
    chk_idle("arst");
    nReset = 1;
    cycle();

    // Reset while a load is pending, then a stray rvalid.
    load(5'd10, 64'h3001, 3'b000, 64'h0, 0);
    cycle();
    nReset = 0;
    #2;
    chk_idle("wrst");
    pend = 0;
    nReset = 1;
    idle_inputs();
    dmem_rvalid = 1; dmem_rdata = 64'h1111_2222;
    cycle();
    chk("stray_lit_v", {63'd0, v32}, 64'd0);

    load(5'd11, 64'h4004, 3'b110, 64'hFFFF_FFFF_8000_0000, 1);
    cycle();
    chk("lwu64_lit", d64, 64'h0000_0000_FFFF_FFFF);
    load(5'd12, 64'h4000, 3'b011, 64'hFFFF_FFFF_8000_0000, 1);
    cycle();
    chk("ld64_lit", d64, 64'hFFFF_FFFF_8000_0000);

    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        in_valid  = ($urandom_range(3) != 0);
        in_rd     = 5'($urandom_range(31));
        if ($urandom_range(7) == 0) in_rd = 0;
        in_result = {32'($urandom), 32'($urandom)};
        in_Wreg   = 1'($urandom);
        in_isLoad = 1'($urandom);
        in_funct3 = 3'($urandom_range(7));
        flush     = ($urandom_range(9) == 0);
      end
      dmem_rvalid = 1'($urandom);
      dmem_rdata  = {32'($urandom), 32'($urandom)};
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
